// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode -- RV32I instruction decode stage with a single registered output
// bundle and valid/ready handshaking on both sides.
//
// An instruction word from fetch is accepted when it is presented, the stage
// is ready and no flush is pending. The decoded fields appear one cycle later
// and stay stable until the execute stage takes them. There is no skid
// buffer: a word offered while o_ready is low is simply dropped, and fetch is
// expected to hold back via the stall line.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-low reset
//   i_clk_en                global clock enable (reset still wins)
//   i_valid, i_inst, i_pc   instruction word and its PC from fetch
//   i_stall                 stall-unit request, blocks acceptance
//   i_flush                 redirect, drops the held bundle and the input word
//   o_ready                 stage can accept an instruction this cycle
//   i_ready                 execute stage takes the bundle this cycle
//   o_valid, o_pc           bundle valid flag and instruction PC
//   o_opcode/funct3/funct7  raw instruction fields
//   o_rd/o_rs1/o_rs2        register indices (rs1/rs2 zeroed when unused)
//   o_rd_we/rs1_en/rs2_en   register write and read enables
//   o_imm                   sign-extended immediate (0 for R-type/illegal)
//   o_illegal               word is not a legal RV32I instruction
// ---------------------------------------------------------------------------
module decode #(
    parameter int AW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clk_en,
    input  logic          i_valid,
    input  logic [31:0]   i_inst,
    input  logic [AW-1:0] i_pc,
    input  logic          i_stall,
    input  logic          i_flush,
    output logic          o_ready,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [AW-1:0] o_pc,
    output logic [6:0]    o_opcode,
    output logic [2:0]    o_funct3,
    output logic [6:0]    o_funct7,
    output logic [4:0]    o_rd,
    output logic [4:0]    o_rs1,
    output logic [4:0]    o_rs2,
    output logic          o_rd_we,
    output logic          o_rs1_en,
    output logic          o_rs2_en,
    output logic [31:0]   o_imm,
    output logic          o_illegal
);

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_idx;

    assign opcode = i_inst[6:0];
    assign funct3 = i_inst[14:12];
    assign funct7 = i_inst[31:25];
    assign rd_idx = i_inst[11:7];

    // Classify the word: format, which register ports it uses and whether
    // the opcode/funct combination exists. Every listed opcode ends in 2'b11,
    // so compressed-space words fall through to the illegal default.
    fmt_e fmt;
    logic dec_legal;
    logic dec_rs1;
    logic dec_rs2;
    logic dec_wr;

    always_comb begin
        fmt       = FMT_R;
        dec_legal = 1'b0;
        dec_rs1   = 1'b0;
        dec_rs2   = 1'b0;
        dec_wr    = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U; dec_legal = 1'b1; dec_wr = 1'b1;
            end
            OPC_JAL: begin
                fmt = FMT_J; dec_legal = 1'b1; dec_wr = 1'b1;
            end
            OPC_JALR: begin
                fmt = FMT_I; dec_legal = (funct3 == 3'b000);
                dec_rs1 = 1'b1; dec_wr = 1'b1;
            end
            OPC_BRANCH: begin
                fmt = FMT_B; dec_legal = (funct3[2:1] != 2'b01);
                dec_rs1 = 1'b1; dec_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                fmt = FMT_I;
                dec_legal = !(funct3 == 3'b011 || funct3[2:1] == 2'b11);
                dec_rs1 = 1'b1; dec_wr = 1'b1;
            end
            OPC_STORE: begin
                fmt = FMT_S; dec_legal = (funct3 < 3'b011);
                dec_rs1 = 1'b1; dec_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                fmt = FMT_I;
                // Shift-immediates reuse the funct7 slot of the immediate.
                if (funct3 == 3'b001)
                    dec_legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101)
                    dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else
                    dec_legal = 1'b1;
                dec_rs1 = 1'b1; dec_wr = 1'b1;
            end
            OPC_OP: begin
                fmt = FMT_R;
                dec_legal = (funct7 == 7'b0000000) ||
                            ((funct7 == 7'b0100000) &&
                             (funct3 == 3'b000 || funct3 == 3'b101));
                dec_rs1 = 1'b1; dec_rs2 = 1'b1; dec_wr = 1'b1;
            end
            OPC_MISC, OPC_SYSTEM: begin
                fmt = FMT_I; dec_legal = 1'b1;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // Immediate assembly per format; zero for R-type and illegal words.
    logic [31:0] dec_imm;

    always_comb begin
        dec_imm = 32'd0;
        if (dec_legal) begin
            case (fmt)
                FMT_I:   dec_imm = {{20{i_inst[31]}}, i_inst[31:20]};
                FMT_S:   dec_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
                FMT_B:   dec_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                                    i_inst[30:25], i_inst[11:8], 1'b0};
                FMT_U:   dec_imm = {i_inst[31:12], 12'd0};
                FMT_J:   dec_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                                    i_inst[20], i_inst[30:21], 1'b0};
                default: dec_imm = 32'd0;
            endcase
        end
    end

    // Handshake. The bundle register is free when empty or being drained.
    logic accept;

    assign o_ready = !i_stall && (!o_valid || i_ready);
    assign accept  = i_clk_en && i_valid && o_ready && !i_flush;

    logic          valid_d,   valid_q;
    logic [AW-1:0] pc_d,      pc_q;
    logic [6:0]    opcode_d,  opcode_q;
    logic [2:0]    funct3_d,  funct3_q;
    logic [6:0]    funct7_d,  funct7_q;
    logic [4:0]    rd_d,      rd_q;
    logic [4:0]    rs1_d,     rs1_q;
    logic [4:0]    rs2_d,     rs2_q;
    logic          rd_we_d,   rd_we_q;
    logic          rs1_en_d,  rs1_en_q;
    logic          rs2_en_d,  rs2_en_q;
    logic [31:0]   imm_d,     imm_q;
    logic          illegal_d, illegal_q;

    // Flush beats accept, accept beats drain; otherwise the bundle holds.
    // Fields are only reloaded on accept, so a drained bundle keeps stale data.
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        funct3_d  = funct3_q;
        funct7_d  = funct7_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_we_d   = rd_we_q;
        rs1_en_d  = rs1_en_q;
        rs2_en_d  = rs2_en_q;
        imm_d     = imm_q;
        illegal_d = illegal_q;
        if (i_clk_en) begin
            if (i_flush) begin
                valid_d = 1'b0;
            end else if (accept) begin
                valid_d   = 1'b1;
                pc_d      = i_pc;
                opcode_d  = opcode;
                funct3_d  = funct3;
                funct7_d  = funct7;
                rd_d      = rd_idx;
                rs1_en_d  = dec_legal && dec_rs1;
                rs2_en_d  = dec_legal && dec_rs2;
                rs1_d     = (dec_legal && dec_rs1) ? i_inst[19:15] : 5'd0;
                rs2_d     = (dec_legal && dec_rs2) ? i_inst[24:20] : 5'd0;
                rd_we_d   = dec_legal && dec_wr && (rd_idx != 5'd0);
                imm_d     = dec_imm;
                illegal_d = !dec_legal;
            end else if (o_valid && i_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            opcode_q  <= 7'd0;
            funct3_q  <= 3'd0;
            funct7_q  <= 7'd0;
            rd_q      <= 5'd0;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            rd_we_q   <= 1'b0;
            rs1_en_q  <= 1'b0;
            rs2_en_q  <= 1'b0;
            imm_q     <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            funct3_q  <= funct3_d;
            funct7_q  <= funct7_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_we_q   <= rd_we_d;
            rs1_en_q  <= rs1_en_d;
            rs2_en_q  <= rs2_en_d;
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_pc      = pc_q;
    assign o_opcode  = opcode_q;
    assign o_funct3  = funct3_q;
    assign o_funct7  = funct7_q;
    assign o_rd      = rd_q;
    assign o_rs1     = rs1_q;
    assign o_rs2     = rs2_q;
    assign o_rd_we   = rd_we_q;
    assign o_rs1_en  = rs1_en_q;
    assign o_rs2_en  = rs2_en_q;
    assign o_imm     = imm_q;
    assign o_illegal = illegal_q;

endmodule

// File: tb/tb_decode.sv
// ---------------------------------------------------------------------------
// tb_decode -- self-checking bench for the decode stage.
//
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A scoreboard queue holds the bundle the stage should currently present;
// tick() updates it from the handshake inputs at each rising edge, and each
// test task compares the DUT against it plus a few hand-computed constants.
// ---------------------------------------------------------------------------
module tb_decode;

    localparam int AW = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rd_we;
        logic        rs1_en;
        logic        rs2_en;
        logic [31:0] imm;
        logic        illegal;
    } bundle_t;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_clk_en;
    logic          i_valid;
    logic [31:0]   i_inst;
    logic [AW-1:0] i_pc;
    logic          i_stall;
    logic          i_flush;
    logic          o_ready;
    logic          i_ready;
    logic          o_valid;
    logic [AW-1:0] o_pc;
    logic [6:0]    o_opcode;
    logic [2:0]    o_funct3;
    logic [6:0]    o_funct7;
    logic [4:0]    o_rd;
    logic [4:0]    o_rs1;
    logic [4:0]    o_rs2;
    logic          o_rd_we;
    logic          o_rs1_en;
    logic          o_rs2_en;
    logic [31:0]   o_imm;
    logic          o_illegal;

    int errors = 0;
    int checks = 0;
    bundle_t sb[$];

    decode #(.AW(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en), .i_valid(i_valid),
        .i_inst(i_inst), .i_pc(i_pc), .i_stall(i_stall), .i_flush(i_flush),
        .o_ready(o_ready), .i_ready(i_ready), .o_valid(o_valid), .o_pc(o_pc),
        .o_opcode(o_opcode), .o_funct3(o_funct3), .o_funct7(o_funct7),
        .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd_we(o_rd_we),
        .o_rs1_en(o_rs1_en), .o_rs2_en(o_rs2_en), .o_imm(o_imm),
        .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    // Reference decoder written opcode by opcode from the ISA tables.
    function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        bundle_t b;
        logic [2:0] f3;
        logic [6:0] f7;
        logic legal, r1, r2, wr;
        logic [31:0] imm;
        f3 = w[14:12];
        f7 = w[31:25];
        legal = 1'b0; r1 = 1'b0; r2 = 1'b0; wr = 1'b0; imm = 32'd0;
        case (w[6:0])
            7'h37, 7'h17: begin legal = 1'b1; wr = 1'b1; imm = {w[31:12], 12'd0}; end
            7'h6F: begin
                legal = 1'b1; wr = 1'b1;
                imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            end
            7'h67: begin legal = (f3 == 0); r1 = 1'b1; wr = 1'b1; imm = {{20{w[31]}}, w[31:20]}; end
            7'h63: begin
                legal = !(f3 == 2 || f3 == 3); r1 = 1'b1; r2 = 1'b1;
                imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            end
            7'h03: begin
                legal = !(f3 == 3 || f3 == 6 || f3 == 7); r1 = 1'b1; wr = 1'b1;
                imm = {{20{w[31]}}, w[31:20]};
            end
            7'h23: begin legal = (f3 <= 2); r1 = 1'b1; r2 = 1'b1; imm = {{20{w[31]}}, w[31:25], w[11:7]}; end
            7'h13: begin
                if (f3 == 1)      legal = (f7 == 7'h00);
                else if (f3 == 5) legal = (f7 == 7'h00 || f7 == 7'h20);
                else              legal = 1'b1;
                r1 = 1'b1; wr = 1'b1; imm = {{20{w[31]}}, w[31:20]};
            end
            7'h33: begin
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                r1 = 1'b1; r2 = 1'b1; wr = 1'b1;
            end
            7'h0F, 7'h73: begin legal = 1'b1; imm = {{20{w[31]}}, w[31:20]}; end
            default: legal = 1'b0;
        endcase
        b = '0;
        b.pc = pc; b.opcode = w[6:0]; b.funct3 = f3; b.funct7 = f7; b.rd = w[11:7];
        b.illegal = !legal;
        if (legal) begin
            b.rs1_en = r1; b.rs2_en = r2;
            b.rs1 = r1 ? w[19:15] : 5'd0;
            b.rs2 = r2 ? w[24:20] : 5'd0;
            b.rd_we = wr && (w[11:7] != 0);
            b.imm = imm;
        end
        return b;
    endfunction

    function automatic bundle_t observed();
        bundle_t b;
        b.pc = o_pc; b.opcode = o_opcode; b.funct3 = o_funct3; b.funct7 = o_funct7;
        b.rd = o_rd; b.rs1 = o_rs1; b.rs2 = o_rs2; b.rd_we = o_rd_we;
        b.rs1_en = o_rs1_en; b.rs2_en = o_rs2_en; b.imm = o_imm; b.illegal = o_illegal;
        return b;
    endfunction

    // Advance one clock; the scoreboard follows the handshake rules.
    task automatic tick();
        logic cur, rdy;
        cur = (sb.size() != 0);
        rdy = !i_stall && (!cur || i_ready);
        @(posedge i_clk);
        if (!i_rst) begin
            sb.delete();
        end else if (i_clk_en) begin
            if (i_flush) begin
                sb.delete();
            end else if (i_valid && rdy) begin
                if (cur) void'(sb.pop_front());
                sb.push_back(ref_decode(i_inst, i_pc));
            end else if (cur && i_ready) begin
                void'(sb.pop_front());
            end
        end
        @(negedge i_clk);
    endtask

    task automatic idle_inputs();
        i_rst = 1'b1; i_clk_en = 1'b1; i_valid = 1'b0; i_inst = 32'd0;
        i_pc = '0; i_stall = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rst = 1'b0; i_valid = 1'b1; i_inst = 32'h00500093; i_pc = 32'h40;
        tick();
        tick();
        checks++;
        if (o_valid !== 1'b0 || observed() !== bundle_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset_state: valid=%b bundle=%h want valid=0 bundle=0", o_valid, observed());
        end
        i_rst = 1'b1; i_valid = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b want 1", o_ready);
        end
    endtask

    task automatic test_addi();
        idle_inputs();
        i_valid = 1'b1; i_inst = 32'h00500093; i_pc = 32'h10;
        tick();
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_rd !== 5'd1 || o_rd_we !== 1'b1 || o_rs1_en !== 1'b1 ||
            o_rs1 !== 5'd0 || o_imm !== 32'd5 || o_pc !== 32'h10 || o_illegal !== 1'b0) begin
            errors++;
            $display("[TB] FAIL addi_fields: valid=%b rd=%0d we=%b rs1en=%b rs1=%0d imm=%h pc=%h want 1,1,1,1,0,5,10",
                     o_valid, o_rd, o_rd_we, o_rs1_en, o_rs1, o_imm, o_pc);
        end
        checks++;
        if (sb.size() != 1 || observed() !== sb[0]) begin
            errors++;
            $display("[TB] FAIL addi_bundle: got %h want %h", observed(), sb.size() != 0 ? sb[0] : bundle_t'(0));
        end
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL addi_drain: valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_branch();
        idle_inputs();
        i_valid = 1'b1; i_inst = 32'hFE209EE3; i_pc = 32'h24;
        tick();
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_imm !== 32'hFFFFFFFC || o_rs1_en !== 1'b1 || o_rs2_en !== 1'b1 ||
            o_rs1 !== 5'd1 || o_rs2 !== 5'd2 || o_rd_we !== 1'b0 || o_illegal !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bne_fields: valid=%b imm=%h rs1en=%b rs2en=%b rs1=%0d rs2=%0d we=%b ill=%b",
                     o_valid, o_imm, o_rs1_en, o_rs2_en, o_rs1, o_rs2, o_rd_we, o_illegal);
        end
        tick();
    endtask

    task automatic test_hold();
        bundle_t held;
        idle_inputs();
        i_ready = 1'b0; i_valid = 1'b1; i_inst = 32'h0041A283; i_pc = 32'h100;
        tick();
        held = ref_decode(32'h0041A283, 32'h100);
        for (int k = 0; k < 4; k++) begin
            i_inst = 32'h00128293 + (k << 20); i_pc = 32'h104 + 4 * k;
            i_stall = (k == 3);
            #1;
            checks++;
            if (o_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_ready[%0d]: got %b want 0", k, o_ready);
            end
            tick();
            checks++;
            if (o_valid !== 1'b1 || observed() !== held) begin
                errors++;
                $display("[TB] FAIL hold_bundle[%0d]: valid=%b got %h want %h", k, o_valid, observed(), held);
            end
        end
        i_stall = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_release_ready: got %b want 1", o_ready);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_release_valid: got %b want 0", o_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [4];
        words[0] = 32'h00100093; words[1] = 32'h00208133;
        words[2] = 32'h123451B7; words[3] = 32'h0080026F;
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1; i_inst = words[k]; i_pc = 32'h200 + 4 * k;
            tick();
            checks++;
            if (o_valid !== 1'b1 || sb.size() != 1 || observed() !== sb[0]) begin
                errors++;
                $display("[TB] FAIL b2b[%0d]: valid=%b got %h want %h", k, o_valid, observed(),
                         ref_decode(words[k], 32'h200 + 4 * k));
            end
        end
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1; i_inst = words[k]; i_pc = 32'h300 + 4 * k;
            i_flush = (k == 2);
            tick();
            checks++;
            if (o_valid !== (k != 2) || (k != 2 && observed() !== ref_decode(words[k], 32'h300 + 4 * k))) begin
                errors++;
                $display("[TB] FAIL flush_seq[%0d]: valid=%b got %h want valid=%b", k, o_valid, observed(), k != 2);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_illegal();
        logic [31:0] words [13];
        logic        ill   [13];
        words[0]  = 32'h00000000; ill[0]  = 1'b1;
        words[1]  = 32'hFFFFFFFF; ill[1]  = 1'b1;
        words[2]  = 32'h4000F033; ill[2]  = 1'b1;
        words[3]  = 32'h0000200F; ill[3]  = 1'b0;
        words[4]  = 32'h00001067; ill[4]  = 1'b1;
        words[5]  = 32'h00002063; ill[5]  = 1'b1;
        words[6]  = 32'h00003003; ill[6]  = 1'b1;
        words[7]  = 32'h00003023; ill[7]  = 1'b1;
        words[8]  = 32'h02001013; ill[8]  = 1'b1;
        words[9]  = 32'h40005013; ill[9]  = 1'b0;
        words[10] = 32'h40000033; ill[10] = 1'b0;
        words[11] = 32'h00000073; ill[11] = 1'b0;
        words[12] = 32'h00000012; ill[12] = 1'b1;
        idle_inputs();
        for (int k = 0; k < 13; k++) begin
            i_valid = 1'b1; i_inst = words[k]; i_pc = 32'h400 + 4 * k;
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_illegal !== ill[k] ||
                (ill[k] && (o_rd_we !== 1'b0 || o_imm !== 32'd0 || o_rs1_en !== 1'b0 || o_rs2_en !== 1'b0))) begin
                errors++;
                $display("[TB] FAIL illegal_flag[%0d]: inst=%h valid=%b ill=%b we=%b imm=%h want ill=%b",
                         k, words[k], o_valid, o_illegal, o_rd_we, o_imm, ill[k]);
            end
            checks++;
            if (sb.size() != 1 || observed() !== sb[0]) begin
                errors++;
                $display("[TB] FAIL illegal_bundle[%0d]: got %h want %h", k, observed(),
                         ref_decode(words[k], 32'h400 + 4 * k));
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_clk_en_reset();
        bundle_t held;
        idle_inputs();
        i_ready = 1'b0; i_valid = 1'b1; i_inst = 32'h00C58513; i_pc = 32'h500;
        tick();
        held = ref_decode(32'h00C58513, 32'h500);
        i_clk_en = 1'b0; i_ready = 1'b1; i_flush = 1'b1; i_inst = 32'h00000093;
        tick();
        checks++;
        if (o_valid !== 1'b1 || observed() !== held) begin
            errors++;
            $display("[TB] FAIL clk_en_hold: valid=%b got %h want %h", o_valid, observed(), held);
        end
        i_flush = 1'b0; i_rst = 1'b0;
        tick();
        checks++;
        if (o_valid !== 1'b0 || observed() !== bundle_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset_gated: valid=%b got %h want all zero", o_valid, observed());
        end
        i_rst = 1'b1; i_clk_en = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: got %b want 1", o_ready);
        end
    endtask

    task automatic test_random();
        logic [6:0] opcs [11];
        logic       exp_ready;
        opcs[0] = 7'h37; opcs[1] = 7'h17; opcs[2] = 7'h6F; opcs[3] = 7'h67;
        opcs[4] = 7'h63; opcs[5] = 7'h03; opcs[6] = 7'h23; opcs[7] = 7'h13;
        opcs[8] = 7'h33; opcs[9] = 7'h0F; opcs[10] = 7'h73;
        idle_inputs();
        for (int n = 0; n < 400; n++) begin
            i_rst    = ($urandom_range(0, 39) != 0);
            i_clk_en = ($urandom_range(0, 9) < 8);
            i_flush  = ($urandom_range(0, 9) == 0);
            i_stall  = ($urandom_range(0, 4) == 0);
            i_ready  = ($urandom_range(0, 9) < 6);
            i_valid  = ($urandom_range(0, 9) < 7);
            i_inst   = $urandom;
            if ($urandom_range(0, 3) != 0) i_inst[6:0] = opcs[$urandom_range(0, 10)];
            i_pc = $urandom & 32'hFFFF_FFFC;
            exp_ready = !i_stall && (sb.size() == 0 || i_ready);
            #1;
            checks++;
            if (o_ready !== exp_ready) begin
                errors++;
                $display("[TB] FAIL rand_ready[%0d]: got %b want %b", n, o_ready, exp_ready);
            end
            tick();
            checks++;
            if (o_valid !== (sb.size() != 0) || (sb.size() != 0 && observed() !== sb[0])) begin
                errors++;
                $display("[TB] FAIL rand_bundle[%0d]: valid=%b got %h want valid=%b %h", n, o_valid,
                         observed(), sb.size() != 0, sb.size() != 0 ? sb[0] : bundle_t'(0));
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_addi();
        test_branch();
        test_hold();
        test_back_to_back();
        test_illegal();
        test_clk_en_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter AW, default 32, PC/address width.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-low.
REQ-004 i_clk_en  input  1  clock enable; when 0 all state holds (reset excepted).
REQ-005 i_valid  input  1  instruction word present from fetch stage (fetch o_pc_inc pulse).
REQ-006 i_inst  input  32  RV32I instruction word from fetch stage.
REQ-007 i_pc  input  AW  PC of i_inst.
REQ-008 i_stall  input  1  stall-unit line; blocks acceptance.
REQ-009 i_flush  input  1  discard held instruction (branch/jump redirect).
REQ-010 o_ready  output  1  decode can accept i_inst this cycle.
REQ-011 i_ready  input  1  downstream (execute) accepts output this cycle.
REQ-012 o_valid  output  1  decoded bundle valid.
REQ-013 o_pc  output  AW  registered PC of decoded instruction.
REQ-014 o_opcode  output  7  inst[6:0]; o_funct3 output 3 inst[14:12]; o_funct7 output 7 inst[31:25].
REQ-015 o_rd / o_rs1 / o_rs2  output  5 each  register indices.
REQ-016 o_rd_we / o_rs1_en / o_rs2_en  output  1 each  register write / read enables.
REQ-017 o_imm  output  32  sign-extended immediate.
REQ-018 o_illegal  output  1  instruction not legal RV32I.

Function
REQ-019 o_ready SHALL be combinational: !i_stall && (!o_valid || i_ready).
REQ-020 Accept SHALL occur on edge where i_clk_en && i_valid && o_ready && !i_flush; outputs register next edge (latency 1 cycle), o_valid<=1.
REQ-021 When o_valid && i_ready && no accept, o_valid SHALL go 0 next edge; bundle fields may hold stale values.
REQ-022 When o_valid && !i_ready, all outputs SHALL hold unchanged (including while i_stall).
REQ-023 Accept and consume in same cycle SHALL replace bundle with no bubble (back-to-back throughput 1/cycle).
REQ-024 i_flush (with i_clk_en) SHALL force o_valid<=0 next edge, overriding accept and hold; i_valid that cycle is dropped.
REQ-025 i_valid while o_ready=0 SHALL be dropped (fetch stalls via i_stall; no buffering).
REQ-026 Immediates: I = {20{inst[31]},inst[31:20]}; S = {20{inst[31]},inst[31:25],inst[11:7]}; B = {19{inst[31]},inst[31],inst[7],inst[30:25],inst[11:8],0}; U = {inst[31:12],12'b0}; J = {11{inst[31]},inst[31],inst[19:12],inst[20],inst[30:21],0}; R-type and illegal -> 0.
REQ-027 Format by opcode: LUI 0110111 U; AUIPC 0010111 U; JAL 1101111 J; JALR 1100111 I; BRANCH 1100011 B; LOAD 0000011 I; STORE 0100011 S; OP-IMM 0010011 I; OP 0110011 R; MISC-MEM 0001111 I; SYSTEM 1110011 I.
REQ-028 o_rs1_en=1 for JALR, BRANCH, LOAD, STORE, OP-IMM, OP; o_rs2_en=1 for BRANCH, STORE, OP; else 0; o_rs1/o_rs2 forced 0 when disabled.
REQ-029 o_rd_we=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP with rd!=0; 0 for rd==x0, BRANCH, STORE, MISC-MEM, SYSTEM, illegal.
REQ-030 o_illegal=1 when: inst[1:0]!=11; opcode not in REQ-027; JALR funct3!=000; BRANCH funct3 010/011; LOAD funct3 011/110/111; STORE funct3>=011; OP funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101; OP-IMM funct3 001 with funct7!=0000000, funct3 101 with funct7 not 0000000/0100000.
REQ-031 Illegal instructions SHALL still be accepted and presented with o_valid=1, o_illegal=1, all enables 0, o_imm=0.
REQ-032 i_inst=0x00000000 and 0xFFFFFFFF SHALL decode illegal.

Reset
REQ-033 !i_rst at a rising edge SHALL set o_valid, o_illegal, enables, o_pc, o_imm and all field outputs to 0, irrespective of i_clk_en.
REQ-034 Reset mid-hold SHALL discard held bundle; o_ready=1 first cycle after release if i_stall=0.

Verification
REQ-035 i_inst=0x00500093 (addi x1,x0,5), i_pc=0x10, accept -> next cycle o_valid=1, o_rd=1, o_rd_we=1, o_rs1_en=1, o_rs1=0, o_imm=5, o_pc=0x10.
REQ-036 i_inst=0xFE209EE3 (bne x1,x2,-4) -> o_imm=0xFFFFFFFC, o_rs1_en=o_rs2_en=1, o_rd_we=0, o_illegal=0.
REQ-037 i_ready=0 for 3 cycles with new i_valid each cycle -> bundle unchanged, o_ready=0, later words dropped; i_ready=1 -> o_valid falls next edge.
REQ-038 Continuous i_valid, i_ready=1: 4 sequential words -> 4 consecutive o_valid cycles, no bubbles; i_flush in cycle 2 -> o_valid=0 next cycle, word 2 lost.
REQ-039 i_inst=0x00000000, 0x0000200F... sweep: 0x00000000 and 0x4000F033 (funct7 0100000, funct3 111) -> o_illegal=1, o_rd_we=0, o_imm=0.
REQ-040 i_rst=0 asserted while o_valid=1 and i_clk_en=0 -> all outputs 0 next edge.
